// File: rtl/sext_chan_pipe.sv
// sext_chan_pipe: 2-entry valid/ready buffer that sign/zero-extends
// packed narrow channels and keeps saturating per-channel negative counts.
module sext_chan_pipe #(
  parameter int IN_W     = 2,
  parameter int OUT_W    = 32,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  input  logic [CHANNELS-1:0]       cfg_sign,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic [CHANNELS-1:0]       out_neg,
  input  logic                      clr_count,
  output logic [CHANNELS*CNT_W-1:0] neg_count
);

  localparam int DW = CHANNELS * IN_W;

  logic [DW-1:0]       r_d0;
  logic [DW-1:0]       r_d1;
  logic [CHANNELS-1:0] r_s0;
  logic [CHANNELS-1:0] r_s1;
  logic [1:0]          r_occ;
  logic                w_push;
  logic                w_pop;

  assign in_ready  = (r_occ != 2'd2);
  assign out_valid = (r_occ != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_s0  <= '0;
      r_s1  <= '0;
      r_occ <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_d0 <= in_data;
            r_s0 <= cfg_sign;
          end else begin
            r_d1 <= in_data;
            r_s1 <= cfg_sign;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_s0  <= r_s1;
          r_d1  <= '0;
          r_s1  <= '0;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          r_d0 <= in_data;
          r_s0 <= cfg_sign;
        end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [IN_W-1:0]  w_f;
    logic             w_neg;
    logic [CNT_W-1:0] r_cnt;

    assign w_f        = r_d0[c*IN_W +: IN_W];
    assign w_neg      = r_s0[c] & w_f[IN_W-1];
    assign out_neg[c] = w_neg;
    assign neg_count[c*CNT_W +: CNT_W] = r_cnt;

    if (OUT_W > IN_W) begin : g_ext
      assign out_data[c*OUT_W +: OUT_W] =
        {{(OUT_W-IN_W){w_neg}}, w_f};
    end else begin : g_pass
      assign out_data[c*OUT_W +: OUT_W] = w_f;
    end

    // Saturating negative counter; clear beats a same-edge increment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (clr_count) begin
        r_cnt <= '0;
      end else if (w_pop && w_neg && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sext_chan_pipe.sv
// Bench for sext_chan_pipe: three instances share stimulus and are
// compared against a queue-based reference model every cycle.
module tb_sext_chan_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_count = 1'b0;
  logic [7:0] in_data   = '0;
  logic [3:0] cfg_sign  = '0;

  logic         a_ir, a_ov;
  logic [127:0] a_od;
  logic [3:0]   a_on;
  logic [31:0]  a_nc;
  logic         b_ir, b_ov;
  logic [127:0] b_od;
  logic [3:0]   b_on;
  logic [7:0]   b_nc;
  logic         w_ir, w_ov;
  logic [7:0]   w_od;
  logic [3:0]   w_on;
  logic [31:0]  w_nc;

  sext_chan_pipe #(.IN_W(2), .OUT_W(32), .CHANNELS(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(in_data), .cfg_sign(cfg_sign), .out_valid(a_ov),
    .out_ready(out_ready), .out_data(a_od), .out_neg(a_on),
    .clr_count(clr_count), .neg_count(a_nc));

  sext_chan_pipe #(.IN_W(2), .OUT_W(32), .CHANNELS(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ir),
    .in_data(in_data), .cfg_sign(cfg_sign), .out_valid(b_ov),
    .out_ready(out_ready), .out_data(b_od), .out_neg(b_on),
    .clr_count(clr_count), .neg_count(b_nc));

  sext_chan_pipe #(.IN_W(2), .OUT_W(2), .CHANNELS(4), .CNT_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_ir),
    .in_data(in_data), .cfg_sign(cfg_sign), .out_valid(w_ov),
    .out_ready(out_ready), .out_data(w_od), .out_neg(w_on),
    .clr_count(clr_count), .neg_count(w_nc));

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] s;
  } beat_t;

  beat_t q[$];
  int    cnt_a[4];
  int    cnt_b[4];
  int    nvec = 0;
  int    nerr = 0;

  // Signed or unsigned integer value of channel c of a beat.
  function automatic int val(beat_t b, int c);
    int v;
    v = int'(b.d[c*2 +: 2]);
    if (b.s[c] && v >= 2) v = v - 4;
    return v;
  endfunction

  function automatic logic [127:0] wide(beat_t b);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[c*32 +: 32] = 32'(val(b, c));
    return r;
  endfunction

  function automatic logic [7:0] narrow(beat_t b);
    logic [7:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[c*2 +: 2] = 2'(val(b, c));
    return r;
  endfunction

  function automatic logic [3:0] negv(beat_t b);
    logic [3:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[c] = (val(b, c) < 0);
    return r;
  endfunction

  function automatic logic [353:0] expected();
    logic [127:0] d;
    logic [7:0]   wd;
    logic [3:0]   n;
    logic [31:0]  ca;
    logic [7:0]   cb;
    logic         v;
    logic         r;
    d = '0;
    wd = '0;
    n = '0;
    v = (q.size() > 0);
    r = (q.size() < 2);
    if (v) begin
      d  = wide(q[0]);
      wd = narrow(q[0]);
      n  = negv(q[0]);
    end
    for (int c = 0; c < 4; c++) begin
      ca[c*8 +: 8] = 8'(cnt_a[c]);
      cb[c*2 +: 2] = 2'(cnt_b[c]);
    end
    return {v, r, d, n, ca, v, r, d, n, cb, v, r, wd, n, ca};
  endfunction

  // Data/neg are only meaningful while the model holds a beat.
  function automatic logic [353:0] observe();
    logic m;
    m = (q.size() > 0);
    return {a_ov, a_ir, m ? a_od : 128'd0, m ? a_on : 4'd0, a_nc,
            b_ov, b_ir, m ? b_od : 128'd0, m ? b_on : 4'd0, b_nc,
            w_ov, w_ir, m ? w_od : 8'd0, m ? w_on : 4'd0, w_nc};
  endfunction

  task automatic tick(input bit iv, input logic [7:0] d,
                      input logic [3:0] s, input bit ordy, input bit clr);
    bit    push;
    bit    pop;
    beat_t h;
    beat_t nb;
    in_valid  = iv;
    in_data   = d;
    cfg_sign  = s;
    out_ready = ordy;
    clr_count = clr;
    push = iv && (q.size() < 2);
    pop  = ordy && (q.size() > 0);
    nb.d = d;
    nb.s = s;
    @(posedge clk);
    if (pop) begin
      h = q.pop_front();
      for (int c = 0; c < 4; c++) begin
        if (val(h, c) < 0) begin
          if (cnt_a[c] < 255) cnt_a[c]++;
          if (cnt_b[c] < 3) cnt_b[c]++;
        end
      end
    end
    if (clr) begin
      for (int c = 0; c < 4; c++) begin
        cnt_a[c] = 0;
        cnt_b[c] = 0;
      end
    end
    if (push) q.push_back(nb);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 8) begin
      tick(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      n++;
    end
    nvec++;
    if (q.size() != 0 || a_ov !== 1'b0) begin
      nerr++;
      $display("FAIL drain: out_valid=%b left=%0d want empty", a_ov, q.size());
    end
  endtask

  task automatic test_sign_ext();
    drain();
    tick(1'b1, 8'b11_10_01_11, 4'b0101, 1'b0, 1'b0);
    nvec++;
    if ({a_ov, a_od, a_on} !==
        {1'b1, 32'h00000003, 32'hFFFFFFFE, 32'h00000001,
         32'hFFFFFFFF, 4'b0101}) begin
      nerr++;
      $display("FAIL sign_ext: got %b %h %b want 1 00000003_FFFFFFFE_00000001_FFFFFFFF 0101",
               a_ov, a_od, a_on);
    end
    nvec++;
    if (observe() !== expected()) begin
      nerr++;
      $display("FAIL sign_ext_model: got %h want %h", observe(), expected());
    end
    drain();
  endtask

  task automatic test_backpressure();
    beat_t          bt[3];
    logic [127:0]   got[$];
    int             nx;
    int             n;
    drain();
    for (int i = 0; i < 3; i++) begin
      bt[i].d = 8'($urandom);
      bt[i].s = 4'($urandom);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, bt[i].d, bt[i].s, 1'b0, 1'b0);
      nvec++;
      if (observe() !== expected()) begin
        nerr++;
        $display("FAIL bp_fill%0d: got %h want %h", i, observe(), expected());
      end
    end
    nvec++;
    if (a_ir !== 1'b0 || q.size() != 2) begin
      nerr++;
      $display("FAIL bp_full: in_ready=%b want 0", a_ir);
    end
    nx = 2;
    n = 0;
    while ((nx < 3 || q.size() > 0) && n < 10) begin
      if (a_ov === 1'b1) got.push_back(a_od);
      if (nx < 3 && q.size() < 2) begin
        tick(1'b1, bt[nx].d, bt[nx].s, 1'b1, 1'b0);
        nx++;
      end else begin
        tick(nx < 3, bt[2].d, bt[2].s, 1'b1, 1'b0);
      end
      n++;
      nvec++;
      if (observe() !== expected()) begin
        nerr++;
        $display("FAIL bp_drain: got %h want %h", observe(), expected());
      end
    end
    nvec++;
    if (got.size() != 3) begin
      nerr++;
      $display("FAIL bp_count: got %0d beats want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (got[i] !== wide(bt[i])) begin
          nerr++;
          $display("FAIL bp_order%0d: got %h want %h", i, got[i], wide(bt[i]));
        end
      end
    end
  endtask

  task automatic test_saturation();
    drain();
    tick(1'b0, 8'h00, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b1, 8'b00_00_00_11, 4'b0001, 1'b1, 1'b0);
    nvec++;
    if (b_nc[1:0] !== 2'd3 || a_nc[7:0] !== 8'd5) begin
      nerr++;
      $display("FAIL sat: got b=%0d a=%0d want b=3 a=5", b_nc[1:0], a_nc[7:0]);
    end
    nvec++;
    if (observe() !== expected()) begin
      nerr++;
      $display("FAIL sat_model: got %h want %h", observe(), expected());
    end
    tick(1'b0, 8'h00, 4'h0, 1'b1, 1'b1);
    nvec++;
    if (b_nc !== 8'd0 || a_nc !== 32'd0 || a_ov !== 1'b0) begin
      nerr++;
      $display("FAIL clr_wins: got b=%h a=%h want 0", b_nc, a_nc);
    end
  endtask

  task automatic test_width_corner();
    drain();
    tick(1'b1, 8'b00_00_00_10, 4'b0001, 1'b0, 1'b0);
    nvec++;
    if (w_od[1:0] !== 2'b10 || w_on[0] !== 1'b1) begin
      nerr++;
      $display("FAIL width: got %b neg %b want 10 neg 1", w_od[1:0], w_on[0]);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      nvec++;
      if (observe() !== expected()) begin
        nerr++;
        $display("FAIL random%0d: got %h want %h", i, observe(), expected());
      end
    end
  endtask

  task automatic test_reset();
    drain();
    tick(1'b1, 8'($urandom), 4'($urandom), 1'b0, 1'b0);
    tick(1'b1, 8'($urandom), 4'($urandom), 1'b0, 1'b0);
    in_valid  = 1'b0;
    in_data   = 8'($urandom);
    cfg_sign  = 4'($urandom);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({a_ov, a_ir, a_od, a_on, a_nc, b_nc, w_od} !==
        {1'b0, 1'b1, 128'd0, 4'd0, 32'd0, 8'd0, 8'd0}) begin
      nerr++;
      $display("FAIL async_reset: got v=%b r=%b d=%h c=%h want 0 1 0 0",
               a_ov, a_ir, a_od, a_nc);
    end
    q.delete();
    for (int c = 0; c < 4; c++) begin
      cnt_a[c] = 0;
      cnt_b[c] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
      nvec++;
      if (observe() !== expected()) begin
        nerr++;
        $display("FAIL post_reset%0d: got %h want %h", i, observe(), expected());
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      cnt_a[c] = 0;
      cnt_b[c] = 0;
    end
    #3;
    nvec++;
    if ({a_ov, a_ir, a_nc} !== {1'b0, 1'b1, 32'd0}) begin
      nerr++;
      $display("FAIL reset_state: got v=%b r=%b c=%h want 0 1 0", a_ov, a_ir, a_nc);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_sign_ext();
    test_backpressure();
    test_saturation();
    test_width_corner();
    test_random();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sext_chan_pipe.md
# sext_chan_pipe

Multi-channel width-extension pipeline. Each beat carries `CHANNELS` packed narrow fields, each `IN_W` bits wide. The block widens every field to `OUT_W` bits using a per-beat, per-channel signed/unsigned selection, flags negative values, and keeps saturating per-channel negative counts. It sits between a narrow-sample producer and a wide datapath. A 2-entry buffer with valid/ready on both sides provides backpressure.

## Interface
Parameters:
- `IN_W`, default 2: width of each input field; must be ≥ 1.
- `OUT_W`, default 32: width of each output field; must be ≥ `IN_W`.
- `CHANNELS`, default 4: number of packed fields per beat; must be ≥ 1.
- `CNT_W`, default 8: width of each negative counter.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: block can accept a beat.
- `in_data`, input, `CHANNELS*IN_W`: packed fields; channel c occupies `[c*IN_W +: IN_W]`.
- `cfg_sign`, input, `CHANNELS`: bit c=1 treats channel c as signed. Captured with the beat.
- `out_valid`, output, 1: output beat valid.
- `out_ready`, input, 1: sink accepts the beat.
- `out_data`, output, `CHANNELS*OUT_W`: extended fields; channel c occupies `[c*OUT_W +: OUT_W]`.
- `out_neg`, output, `CHANNELS`: bit c=1 when output channel c is negative.
- `clr_count`, input, 1: synchronous clear of all counters.
- `neg_count`, output, `CHANNELS*CNT_W`: per-channel saturating counts of negative beats.

## Operation
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Buffer:
  - 2-entry in-order FIFO; each entry holds `in_data` and `cfg_sign`.
  - Occupancy is registered (0..2).
  - `in_ready` = (occupancy < 2). It has no combinational path from `out_ready`.
- Push: `in_valid & in_ready` at a rising edge writes the tail entry.
- Pop: `out_valid & out_ready` at a rising edge retires the head entry.
- Simultaneous push and pop: allowed when occupancy is 1. Occupancy stays 1, and the new beat becomes the head.
  - When occupancy is 2, no push is possible that cycle even if a pop occurs.
- `out_valid` = (occupancy > 0).
- `out_data` and `out_neg` are driven combinationally from the head entry.
- Extension, per channel c, with m = MSB of the field:
  - If `cfg_sign[c]=1`: upper `OUT_W-IN_W` bits = m (sign extension).
  - If `cfg_sign[c]=0`: upper bits = 0 (zero extension).
  - If `OUT_W == IN_W`: pass-through.
- Negative flag: `out_neg[c]` = `cfg_sign[c] & m`. An unsigned channel is never negative.
- Counters, per channel c, on each pop:
  - The count increments by 1 if `out_neg[c]`.
  - It saturates at 2^`CNT_W`-1 and never wraps.
- Clear: `clr_count=1` sets all counts to 0 at the edge.
  - Clear wins over a simultaneous increment: the result is 0.
  - Clear does not affect the buffer.
- While `out_valid=1` and `out_ready=0`: `out_data`, `out_neg` and the head entry stay stable.

## Timing
- Reset (asynchronous, immediate on `rst_n` low):
  - occupancy = 0, `out_valid` = 0, `out_data` = 0, `out_neg` = 0, all `neg_count` = 0, `in_ready` = 1.
  - Buffer contents reset to 0.
  - The source must hold `in_valid` low while `rst_n` is low.
- Reset mid-operation discards all buffered beats; nothing is emitted after release.
- Latency: a beat accepted at edge N is visible on `out_valid`/`out_data` after edge N, when the buffer was empty.
- Throughput: 1 beat/cycle sustained while `out_ready=1`.
- Counter latency: a count reflects a pop at edge N immediately after edge N.

## Test plan
Parameters for all scenarios unless noted: `IN_W=2`, `OUT_W=32`, `CHANNELS=4`.
- **Reset values:** drive random inputs, pulse `rst_n` low mid-cycle.
  - Required: `out_valid=0`, `in_ready=1`, `out_data=0`, `neg_count=0` immediately, asynchronously.
- **Sign vs zero extension:** push `in_data=8'b11_10_01_11` with `cfg_sign=4'b0101`.
  - Required: ch0 = `32'hFFFFFFFF`, ch1 = `32'h00000001`, ch2 = `32'hFFFFFFFE`, ch3 = `32'h00000003`; `out_neg=4'b0101`.
- **Backpressure:** hold `out_ready=0` and offer 3 consecutive beats A, B, C.
  - Required: A and B accepted; `in_ready=0` after the second edge; C held.
  - Then raise `out_ready`. Required: output order A, B, C with no gaps or duplicates.
- **Saturation and clear (`CNT_W=2`):**
  - 5 popped beats with ch0 negative. Required: `neg_count[1:0]=3`.
  - Assert `clr_count` on the same edge as a 6th negative pop. Required: count = 0.
- **Width corner (`OUT_W=IN_W=2`):** push `2'b10` signed.
  - Required: output `2'b10`, `out_neg=1`.
- **Reset mid-operation:** buffer 2 beats with `out_ready=0`, then reset.
  - Required: `out_valid=0`, occupancy empty, no stale beat appears after release.
